uart_rx_sequencer: RTL and testbench

- Receive sequencer for a serial line that has been cleaned by the team's 3-tap majority filter.
- Detects the start bit, times mid-bit sampling with a bit-period counter, and assembles LSB-first data words.
- Delivers each word through a single-entry valid/ready holding register, and flags framing and overrun errors.
- Sits between the majority filter output and the byte-consumer logic; it is the only block that interprets filtered line timing.

---
 rtl/uart_rx_sequencer_if.sv | 33 +++
 rtl/uart_rx_sequencer.sv | 150 +++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Handshake bundle between the filtered serial line, the receive sequencer and the byte consumer.
// The master side is the sequencer; the slave side is the line driver plus the consumer.
interface uart_rx_sequencer_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rxIn;
  logic [DATA_BITS-1:0] dataOut;
  logic                 validOut;
  logic                 readyIn;
  logic                 frameErrOut;
  logic                 overrunOut;
  logic                 busyOut;

  modport master (
    input  rxIn,
    input  readyIn,
    output dataOut,
    output validOut,
    output frameErrOut,
    output overrunOut,
    output busyOut
  );

  modport slave (
    output rxIn,
    output readyIn,
    input  dataOut,
    input  validOut,
    input  frameErrOut,
    input  overrunOut,
    input  busyOut
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// Receive sequencer: start detect, mid-bit sampling, LSB-first assembly, and a single-entry
// valid/ready holding register with framing and overrun pulses.
module uart_rx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic                 clkIn,
  input logic                 nResetIn,
  uart_rx_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Counter values seen on the sampling edge: the counter restarts at 0 on each transition.
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 word_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!bus.rxIn) begin
          state_d = StStart;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (bus.rxIn) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {bus.rxIn, shift_q[DATA_BITS-1:1]};
          if (bit_q == BitLast) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d = '0;
          if (bus.rxIn) begin
            word_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Held-low line yields a single framing pulse; wait for the line to recover.
        cnt_d = '0;
        if (bus.rxIn) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (word_done) begin
      // An accept on the completion edge frees the slot for the new word.
      if (!valid_q || bus.readyIn) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.readyIn) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!nResetIn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.dataOut     = data_q;
  assign bus.validOut    = valid_q;
  assign bus.frameErrOut = frame_err_q;
  assign bus.overrunOut  = overrun_q;
  assign bus.busyOut     = (state_q != StIdle);

  a_data_stable: assert property (@(posedge clkIn) disable iff (!nResetIn)
    valid_q && !bus.readyIn |=> valid_q && $stable(data_q));

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer with 8 clocks per bit and 8 data bits.
module tb_uart_rx_sequencer;

  localparam int unsigned Cpb = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_sequencer_if #(.DATA_BITS(8)) bus ();

  uart_rx_sequencer #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8)
  ) dut (
    .clkIn   (clk),
    .nResetIn(rst_n),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_t0 = 0;
  int         rise_cyc = -1;
  int         ov_cyc = -1;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         n_acc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted word and tracks pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_acc   <= 1'b0;
    end else begin
      if (bus.validOut && !prev_valid) rise_cyc <= cyc;
      if (bus.validOut && prev_valid && !prev_acc)
        check_eq("data_stable", 32'(bus.dataOut), 32'(prev_data));
      if (bus.frameErrOut) fe_cnt <= fe_cnt + 1;
      if (bus.overrunOut) begin
        ov_cnt <= ov_cnt + 1;
        ov_cyc <= cyc;
      end
      if (bus.validOut && bus.readyIn) begin
        n_acc <= n_acc + 1;
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check_eq("sb_word", 32'(bus.dataOut), 32'(exp_q.pop_front()));
      end
      prev_acc   <= bus.validOut && bus.readyIn;
      prev_valid <= bus.validOut;
      prev_data  <= bus.dataOut;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rxIn = b;
    repeat (Cpb) tick();
  endtask

  // Called aligned 1 time unit after an edge; the next edge is the first to see the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    last_t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  int fe0, ov0, acc0;

  initial begin
    rst_n       = 1'b0;
    bus.rxIn    = 1'b1;
    bus.readyIn = 1'b1;

    // Reset with a toggling line
    for (int i = 0; i < 3; i++) begin
      bus.rxIn = i[0];
      tick();
    end
    check_eq("rst_valid", 32'(bus.validOut), 32'd0);
    check_eq("rst_ferr", 32'(bus.frameErrOut), 32'd0);
    check_eq("rst_ovr", 32'(bus.overrunOut), 32'd0);
    check_eq("rst_busy", 32'(bus.busyOut), 32'd0);
    check_eq("rst_data", 32'(bus.dataOut), 32'd0);
    bus.rxIn = 1'b1;
    rst_n    = 1'b1;
    repeat (5) tick();
    check_eq("idle_busy", 32'(bus.busyOut), 32'd0);
    check_eq("idle_valid", 32'(bus.validOut), 32'd0);

    // Single frame 0xA5
    rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check_eq("a5_latency", 32'(rise_cyc + 1), 32'(last_t0 + 77));
    check_eq("a5_valid_drop", 32'(bus.validOut), 32'd0);
    check_eq("a5_data_kept", 32'(bus.dataOut), 32'hA5);
    repeat (4) tick();

    // False start
    fe0      = fe_cnt;
    acc0     = n_acc;
    bus.rxIn = 1'b0;
    repeat (3) tick();
    bus.rxIn = 1'b1;
    tick();
    check_eq("fs_busy_hi", 32'(bus.busyOut), 32'd1);
    tick();
    check_eq("fs_busy_lo", 32'(bus.busyOut), 32'd0);
    repeat (80) tick();
    check_eq("fs_no_word", 32'(n_acc), 32'(acc0));
    check_eq("fs_no_ferr", 32'(fe_cnt), 32'(fe0));

    // Framing error with held-low line, then recovery
    fe0  = fe_cnt;
    acc0 = n_acc;
    send_frame(8'h3C, 1'b0);
    repeat (20) tick();
    check_eq("fe_one_pulse", 32'(fe_cnt - fe0), 32'd1);
    check_eq("fe_no_valid", 32'(bus.validOut), 32'd0);
    check_eq("fe_no_word", 32'(n_acc), 32'(acc0));
    check_eq("fe_break_busy", 32'(bus.busyOut), 32'd1);
    bus.rxIn = 1'b1;
    repeat (3) tick();
    check_eq("fe_recover_idle", 32'(bus.busyOut), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check_eq("fe_next_data", 32'(bus.dataOut), 32'h5A);
    repeat (4) tick();

    // Overrun: second word dropped while the first is held
    bus.readyIn = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick();
    check_eq("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check_eq("ovr_timing", 32'(ov_cyc), 32'(last_t0 + 76));
    check_eq("ovr_valid_held", 32'(bus.validOut), 32'd1);
    check_eq("ovr_data_kept", 32'(bus.dataOut), 32'h11);
    bus.readyIn = 1'b1;
    tick();
    check_eq("ovr_consumed", 32'(bus.validOut), 32'd0);
    check_eq("ovr_data_after", 32'(bus.dataOut), 32'h11);
    repeat (4) tick();

    // Accept on the same edge as the next word completes
    bus.readyIn = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    ov0 = ov_cnt;
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (76) tick();
        bus.readyIn = 1'b1;
        tick();
        check_eq("sim_valid", 32'(bus.validOut), 32'd1);
        check_eq("sim_data", 32'(bus.dataOut), 32'h77);
      end
    join
    check_eq("sim_no_ovr", 32'(ov_cnt), 32'(ov0));
    check_eq("sim_consumed", 32'(bus.validOut), 32'd0);
    repeat (4) tick();

    // Reset in the middle of the data bits abandons the frame
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    acc0 = n_acc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    bus.rxIn = 1'b1;
    repeat (4) tick();
    check_eq("mid_busy", 32'(bus.busyOut), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_busy", 32'(bus.busyOut), 32'd0);
    check_eq("mid_rst_valid", 32'(bus.validOut), 32'd0);
    repeat (100) tick();
    check_eq("mid_no_word", 32'(n_acc), 32'(acc0));
    check_eq("mid_no_ferr", 32'(fe_cnt), 32'(fe0));
    check_eq("mid_no_ovr", 32'(ov_cnt), 32'(ov0));
    check_eq("mid_busy_end", 32'(bus.busyOut), 32'd0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
